execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the 5-stage RV32I pipeline: consumes the ID/EX register outputs of the decode stage. It resolves forwarded operands, runs the ALU, and computes the branch/jump decision and target back to fetch. It captures the results in the EX/MEM pipeline register, which feeds the memory stage.

## Interface
- Parameters: none (datapath fixed at 32 bits, register index at 5 bits).
- clk  in  1  pipeline clock, all state on rising edge
- srst  in  1  reset, synchronous, active-high
- pc_e, pc_plus4_e  in  32  PC and PC+4 of the instruction in EX
- jump_e, branch_e  in  1  unconditional jump / beq-type branch
- result_src_e  in  2  writeback select (00 ALU, 01 mem, 10 PC+4); passed through only
- mem_write_e, reg_write_e  in  1  store enable / register writeback enable; passed through only
- alu_src_e  in  1  0: src_b = forwarded rd2, 1: src_b = imm_ext_e
- alu_control_e  in  3  ALU op (encoding below)
- rd1_e, rd2_e  in  32  register-file read data
- rs1_e, rs2_e, rd_e  in  5  source and destination register indices
- imm_ext_e  in  32  sign-extended immediate
- forward_a_e, forward_b_e  in  2  hazard-unit forward selects
- result_w  in  32  writeback-stage result (forward source)
- pc_src_e  out  1  1 = fetch redirects to pc_target_e (combinational)
- pc_target_e  out  32  pc_e + imm_ext_e (combinational)
- rs1_h, rs2_h, rd_h  out  5  copies of rs1_e/rs2_e/rd_e to the hazard unit (combinational)
- reg_write_m, mem_write_m  out  1  registered controls
- result_src_m  out  2  registered
- alu_result_m, write_data_m, pc_plus4_m  out  32  registered
- rd_m  out  5  registered

## Operation
- Forward mux A:
  - 00 → rd1_e
  - 01 → result_w
  - 10 → alu_result_m (this block's own registered output)
  - 11 → rd1_e
- Forward mux B: same selects with rd2_e; its output is write_data_e.
- src_a = mux A output. src_b = alu_src_e ? imm_ext_e : write_data_e.
- ALU, 32-bit, result modulo 2^32, no overflow flag:
  - 000 ADD
  - 001 SUB (src_a + ~src_b + 1)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT signed (result 32'd1/32'd0)
  - 110 SLL by src_b[4:0]
  - 111 SRL by src_b[4:0]
  - Upper bits of src_b are ignored for shifts.
- zero = (alu_result_e == 0).
- pc_src_e = jump_e | (branch_e & zero).
- pc_target_e = pc_e + imm_ext_e. Carry-out is dropped, so wrap past 0xFFFF_FFFC is legal.
- EX/MEM register captures on every rising edge: reg_write, result_src, mem_write, alu_result_e, write_data_e, rd_e, pc_plus4_e.
  - No stall and no enable; the hazard unit never stalls EX/MEM.
  - A bubble arrives as all-zero controls from the decode register, so no flush input is needed.
- Jumps: alu_result is don't-care; the link value travels as pc_plus4_m.

## Timing
- Combinational, same cycle as inputs: pc_src_e, pc_target_e, rs*_h, rd_h.
  - The decode stage must register flush_e in time to squash the next ID/EX capture.
- EX→MEM latency: 1 cycle. Values valid at EX in cycle n appear on *_m after edge n+1.
- Reset: a srst sampled high at an edge clears every *_m output to 0 (controls, alu_result_m, write_data_m, pc_plus4_m, rd_m).
  - Applies mid-operation; in-flight state is discarded.
  - While srst is held, *_m stay 0.
  - Combinational outputs follow their inputs and are not gated by srst.
- Forward from alu_result_m uses the value registered at the previous edge, giving back-to-back ALU dependency with zero stall.
- Simultaneous forward hazards on A and B are independent; both may select 10.
- forward = 11 is illegal from the hazard unit but must resolve as 00, with no X propagation.
- rd_e = 0 with reg_write_e = 1 is passed through unchanged; x0 suppression belongs to the register file and hazard unit.

## Test plan
- Reset: drive srst=1 for 2 cycles with nonzero inputs → all *_m read 0; release → the first capture matches the inputs.
- ALU sweep: src_a=0xFFFF_FFF0, imm=0x10, alu_src=1:
  - ADD → alu_result_m = 0x0000_0000
  - SUB → 0xFFFF_FFE0
  - SLT (rd2=1, alu_src=0) → 1
  - SLL by 4 (src_b=0x24) → 0xFFFF_FF00
  - SRL by 4 → 0x0FFF_FFFF
- Back-to-back forwarding: cycle n, ADD rd1=5 + imm 3 → alu_result_m = 8. Cycle n+1, forward_a=10, SUB src_b=imm 2 → alu_result_m = 6.
- Writeback forward: forward_b=01, result_w=0xDEAD_BEEF, mem_write_e=1 → write_data_m = 0xDEAD_BEEF, mem_write_m = 1 next cycle.
- Branch:
  - branch_e=1, SUB 7-7 → pc_src_e = 1 same cycle; pc_target_e = pc_e 0x100 + imm 0xFFFF_FFF8 = 0x0F8.
  - With 7-6 → pc_src_e = 0.
- Jump: jump_e=1, result_src_e=10, pc_plus4_e=0x204 → pc_src_e = 1; next cycle pc_plus4_m = 0x204, result_src_m = 10. Forward select 11 on both muxes yields rd1_e/rd2_e.

Source files
------------

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch resolution
// and the EX/MEM pipeline register.
module execute_stage (
  input  logic        clk,
  input  logic        srst,
  input  logic [31:0] pc_e,
  input  logic [31:0] pc_plus4_e,
  input  logic        jump_e,
  input  logic        branch_e,
  input  logic [1:0]  result_src_e,
  input  logic        mem_write_e,
  input  logic        reg_write_e,
  input  logic        alu_src_e,
  input  logic [2:0]  alu_control_e,
  input  logic [31:0] rd1_e,
  input  logic [31:0] rd2_e,
  input  logic [4:0]  rs1_e,
  input  logic [4:0]  rs2_e,
  input  logic [4:0]  rd_e,
  input  logic [31:0] imm_ext_e,
  input  logic [1:0]  forward_a_e,
  input  logic [1:0]  forward_b_e,
  input  logic [31:0] result_w,
  output logic        pc_src_e,
  output logic [31:0] pc_target_e,
  output logic [4:0]  rs1_h,
  output logic [4:0]  rs2_h,
  output logic [4:0]  rd_h,
  output logic        reg_write_m,
  output logic        mem_write_m,
  output logic [1:0]  result_src_m,
  output logic [31:0] alu_result_m,
  output logic [31:0] write_data_m,
  output logic [31:0] pc_plus4_m,
  output logic [4:0]  rd_m
);

  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] write_data_e;
  logic [31:0] alu_result_e;
  logic        zero;

  // Select 11 is never issued but must fall back to the register file.
  always_comb begin
    case (forward_a_e)
      2'b01:   src_a = result_w;
      2'b10:   src_a = alu_result_m;
      default: src_a = rd1_e;
    endcase
  end

  always_comb begin
    case (forward_b_e)
      2'b01:   write_data_e = result_w;
      2'b10:   write_data_e = alu_result_m;
      default: write_data_e = rd2_e;
    endcase
  end

  assign src_b = alu_src_e ? imm_ext_e : write_data_e;

  always_comb begin
    case (alu_control_e)
      3'b000:  alu_result_e = src_a + src_b;
      3'b001:  alu_result_e = src_a + ~src_b + 32'd1;
      3'b010:  alu_result_e = src_a & src_b;
      3'b011:  alu_result_e = src_a | src_b;
      3'b100:  alu_result_e = src_a ^ src_b;
      3'b101:  alu_result_e = {31'd0, $signed(src_a) < $signed(src_b)};
      3'b110:  alu_result_e = src_a << src_b[4:0];
      default: alu_result_e = src_a >> src_b[4:0];
    endcase
  end

  assign zero        = (alu_result_e == 32'd0);
  assign pc_src_e    = jump_e | (branch_e & zero);
  assign pc_target_e = pc_e + imm_ext_e;

  assign rs1_h = rs1_e;
  assign rs2_h = rs2_e;
  assign rd_h  = rd_e;

  always_ff @(posedge clk) begin
    if (srst) begin
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= 2'b00;
      alu_result_m <= 32'd0;
      write_data_m <= 32'd0;
      pc_plus4_m   <= 32'd0;
      rd_m         <= 5'd0;
    end else begin
      reg_write_m  <= reg_write_e;
      mem_write_m  <= mem_write_e;
      result_src_m <= result_src_e;
      alu_result_m <= alu_result_e;
      write_data_m <= write_data_e;
      pc_plus4_m   <= pc_plus4_e;
      rd_m         <= rd_e;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus
// randomized traffic against a behavioural model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        srst;
  logic [31:0] pc_e, pc_plus4_e;
  logic        jump_e, branch_e;
  logic [1:0]  result_src_e;
  logic        mem_write_e, reg_write_e, alu_src_e;
  logic [2:0]  alu_control_e;
  logic [31:0] rd1_e, rd2_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [31:0] imm_ext_e;
  logic [1:0]  forward_a_e, forward_b_e;
  logic [31:0] result_w;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic [4:0]  rs1_h, rs2_h, rd_h;
  logic        reg_write_m, mem_write_m;
  logic [1:0]  result_src_m;
  logic [31:0] alu_result_m, write_data_m, pc_plus4_m;
  logic [4:0]  rd_m;

  int tests = 0;
  int fails = 0;

  // Model state: what the EX/MEM register should hold.
  logic        e_reg_write, e_mem_write;
  logic [1:0]  e_result_src;
  logic [31:0] e_alu, e_wd, e_pc4;
  logic [4:0]  e_rd;

  execute_stage dut (
    .clk(clk), .srst(srst),
    .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
    .jump_e(jump_e), .branch_e(branch_e),
    .result_src_e(result_src_e),
    .mem_write_e(mem_write_e), .reg_write_e(reg_write_e),
    .alu_src_e(alu_src_e), .alu_control_e(alu_control_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .imm_ext_e(imm_ext_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .result_w(result_w),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .rs1_h(rs1_h), .rs2_h(rs2_h), .rd_h(rd_h),
    .reg_write_m(reg_write_m), .mem_write_m(mem_write_m),
    .result_src_m(result_src_m),
    .alu_result_m(alu_result_m), .write_data_m(write_data_m),
    .pc_plus4_m(pc_plus4_m), .rd_m(rd_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel,
                                      input logic [31:0] rf);
    if (sel == 2'd1) return result_w;
    if (sel == 2'd2) return e_alu;
    return rf;
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
    int sa, sb;
    int unsigned sh;
    sa = int'(a);
    sb = int'(b);
    sh = b % 32;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      3'd6: return a << sh;
      default: return a >> sh;
    endcase
  endfunction

  // Check combinational outputs now, then the registered ones after the edge.
  task automatic cycle();
    logic [31:0] a, wd, b, res;
    #1;
    a   = fwd(forward_a_e, rd1_e);
    wd  = fwd(forward_b_e, rd2_e);
    b   = alu_src_e ? imm_ext_e : wd;
    res = alu(alu_control_e, a, b);
    chk("pc_target", pc_target_e, pc_e + imm_ext_e);
    chk("pc_src", pc_src_e, jump_e | (branch_e & (res == 0)));
    chk("hazard_idx", {rs1_h, rs2_h, rd_h}, {rs1_e, rs2_e, rd_e});
    @(posedge clk);
    if (srst) begin
      {e_reg_write, e_mem_write, e_result_src} = '0;
      {e_alu, e_wd, e_pc4, e_rd} = '0;
    end else begin
      e_reg_write  = reg_write_e;
      e_mem_write  = mem_write_e;
      e_result_src = result_src_e;
      e_alu = res;
      e_wd  = wd;
      e_pc4 = pc_plus4_e;
      e_rd  = rd_e;
    end
    #1;
    chk("ctrl_m", {reg_write_m, mem_write_m, result_src_m},
        {e_reg_write, e_mem_write, e_result_src});
    chk("alu_result_m", alu_result_m, e_alu);
    chk("write_data_m", write_data_m, e_wd);
    chk("pc_plus4_m", pc_plus4_m, e_pc4);
    chk("rd_m", rd_m, e_rd);
  endtask

  task automatic clear_in();
    {jump_e, branch_e, mem_write_e, reg_write_e, alu_src_e} = '0;
    result_src_e = 0; alu_control_e = 0;
    forward_a_e = 0; forward_b_e = 0;
    pc_e = 0; pc_plus4_e = 0; rd1_e = 0; rd2_e = 0;
    imm_ext_e = 0; result_w = 0;
    rs1_e = 0; rs2_e = 0; rd_e = 0;
  endtask

  task automatic rand_in();
    pc_e = $urandom & 32'hFFFF_FFFC;
    pc_plus4_e = pc_e + 4;
    jump_e = ($urandom_range(0, 7) == 0);
    branch_e = $urandom_range(0, 1);
    result_src_e = $urandom_range(0, 3);
    mem_write_e = $urandom_range(0, 1);
    reg_write_e = $urandom_range(0, 1);
    alu_src_e = $urandom_range(0, 1);
    alu_control_e = $urandom_range(0, 7);
    rd1_e = $urandom;
    rd2_e = ($urandom_range(0, 3) == 0) ? rd1_e : $urandom;
    rs1_e = $urandom_range(0, 31);
    rs2_e = $urandom_range(0, 31);
    rd_e = $urandom_range(0, 31);
    imm_ext_e = $urandom;
    forward_a_e = $urandom_range(0, 3);
    forward_b_e = $urandom_range(0, 3);
    result_w = $urandom;
  endtask

  initial begin
    {e_reg_write, e_mem_write, e_result_src} = '0;
    {e_alu, e_wd, e_pc4, e_rd} = '0;
    srst = 1'b1;
    rand_in();
    reg_write_e = 1; mem_write_e = 1; rd_e = 5'd9;
    @(posedge clk); #1;
    // Reset held for two cycles with nonzero inputs
    cycle();
    cycle();
    chk("rst_alu_lit", alu_result_m, 32'd0);
    chk("rst_ctrl_lit", {reg_write_m, mem_write_m, rd_m}, 7'd0);
    srst = 1'b0;
    clear_in();
    rd1_e = 32'd10; imm_ext_e = 32'd20; alu_src_e = 1;
    reg_write_e = 1; rd_e = 5'd3; pc_plus4_e = 32'h44;
    cycle();
    chk("first_cap_lit", alu_result_m, 32'd30);
    chk("first_rd_lit", rd_m, 5'd3);

    // ALU sweep on src_a = 0xFFFF_FFF0
    clear_in();
    rd1_e = 32'hFFFF_FFF0; imm_ext_e = 32'h10; alu_src_e = 1;
    alu_control_e = 3'd0; cycle();
    chk("add_lit", alu_result_m, 32'h0);
    alu_control_e = 3'd1; cycle();
    chk("sub_lit", alu_result_m, 32'hFFFF_FFE0);
    alu_control_e = 3'd5; alu_src_e = 0; rd2_e = 32'd1; cycle();
    chk("slt_lit", alu_result_m, 32'd1);
    alu_control_e = 3'd6; alu_src_e = 1; imm_ext_e = 32'h24; cycle();
    chk("sll_lit", alu_result_m, 32'hFFFF_FF00);
    alu_control_e = 3'd7; imm_ext_e = 32'h4; cycle();
    chk("srl_lit", alu_result_m, 32'h0FFF_FFFF);

    // Back-to-back dependency through alu_result_m
    clear_in();
    rd1_e = 32'd5; imm_ext_e = 32'd3; alu_src_e = 1; cycle();
    chk("b2b_add_lit", alu_result_m, 32'd8);
    rd1_e = 32'h1234_5678; forward_a_e = 2'b10;
    alu_control_e = 3'd1; imm_ext_e = 32'd2; cycle();
    chk("b2b_sub_lit", alu_result_m, 32'd6);

    // Writeback forward into store data
    clear_in();
    forward_b_e = 2'b01; result_w = 32'hDEAD_BEEF;
    rd2_e = 32'h5555_5555; mem_write_e = 1; cycle();
    chk("wb_fwd_lit", write_data_m, 32'hDEAD_BEEF);
    chk("wb_mw_lit", mem_write_m, 1'b1);

    // Branch taken / not taken
    clear_in();
    branch_e = 1; alu_control_e = 3'd1;
    rd1_e = 32'd7; rd2_e = 32'd7;
    pc_e = 32'h100; imm_ext_e = 32'hFFFF_FFF8;
    #1;
    chk("br_taken_lit", pc_src_e, 1'b1);
    chk("br_target_lit", pc_target_e, 32'h0F8);
    cycle();
    rd2_e = 32'd6; #1;
    chk("br_not_lit", pc_src_e, 1'b0);
    cycle();

    // Jump with illegal forward select 11 on both muxes
    clear_in();
    jump_e = 1; result_src_e = 2'b10; pc_plus4_e = 32'h204;
    forward_a_e = 2'b11; forward_b_e = 2'b11;
    rd1_e = 32'd3; rd2_e = 32'd4; result_w = 32'hFFFF;
    #1;
    chk("jmp_src_lit", pc_src_e, 1'b1);
    cycle();
    chk("jmp_pc4_lit", pc_plus4_m, 32'h204);
    chk("jmp_rs_lit", result_src_m, 2'b10);
    chk("fwd11_lit", {alu_result_m, write_data_m}, {32'd7, 32'd4});

    // x0 destination passes straight through
    clear_in();
    reg_write_e = 1; rd_e = 5'd0; cycle();
    chk("x0_lit", {reg_write_m, rd_m}, 6'b1_00000);

    // Randomized traffic with occasional mid-stream reset
    for (int i = 0; i < 400; i++) begin
      rand_in();
      srst = ($urandom_range(0, 24) == 0);
      cycle();
    end
    srst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
